// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types and defaults for the arbitrated APB master
package apb_pkg;

  localparam int APB_AW = 8;
  localparam int APB_DW = 21;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_t;

  typedef struct packed {
    logic              write;
    logic [APB_AW-1:0] addr;
    logic [APB_DW-1:0] wdata;
  } apb_req_t;

endpackage

// File: rtl/apb_arb_master_if.sv
// rtl/apb_arb_master_if.sv - requester, response and APB bus signals of the master
interface apb_arb_master_if
  import apb_pkg::*;
#(
  parameter int AW = APB_AW,
  parameter int DW = APB_DW
);

  logic [1:0]    req_valid;
  logic [1:0]    req_write;
  logic [AW-1:0] req_addr0;
  logic [AW-1:0] req_addr1;
  logic [DW-1:0] req_wdata0;
  logic [DW-1:0] req_wdata1;
  logic [1:0]    req_ready;

  logic          rsp_valid;
  logic          rsp_id;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  logic          PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [3:0]    PWAIT;
  logic          PREADY;
  logic [DW-1:0] PRDATA;

  modport master (
    input  req_valid, req_write, req_addr0, req_addr1, req_wdata0, req_wdata1,
    output req_ready, rsp_valid, rsp_id, rsp_rdata, rsp_err,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PWAIT,
    input  PREADY, PRDATA
  );

  modport slave (
    output req_valid, req_write, req_addr0, req_addr1, req_wdata0, req_wdata1,
    input  req_ready, rsp_valid, rsp_id, rsp_rdata, rsp_err,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PWAIT,
    output PREADY, PRDATA
  );

endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant, one-hot output
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // under contention the requester that did not win last time goes next
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/apb_arb_master.sv
// rtl/apb_arb_master.sv - two-requester round-robin APB master with access timeout
module apb_arb_master
  import apb_pkg::*;
#(
  parameter int         AW       = APB_AW,
  parameter int         DW       = APB_DW,
  parameter logic [3:0] WAIT_CFG = 4'd0,
  parameter int         TIMEOUT  = 16
) (
  input  logic             PCLK,
  input  logic             PRESET,
  apb_arb_master_if.master bus
);

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t        state, state_nxt;
  logic          last_grant;
  logic [7:0]    wait_cnt;
  apb_req_t      cur;
  logic          cur_id;
  logic [DW-1:0] rdata_q;
  logic          err_q;
  logic [1:0]    gnt;
  apb_req_t      req0, req1;

  assign req0 = {bus.req_write[0], bus.req_addr0, bus.req_wdata0};
  assign req1 = {bus.req_write[1], bus.req_addr1, bus.req_wdata1};

  rr_arb2 u_arb (
    .req  (bus.req_valid),
    .last (last_grant),
    .gnt  (gnt)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|bus.req_valid) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (bus.PREADY || wait_cnt == WAIT_LAST) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      wait_cnt   <= '0;
      cur        <= '0;
      cur_id     <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (|gnt) begin
            cur        <= gnt[1] ? req1 : req0;
            cur_id     <= gnt[1];
            last_grant <= gnt[1];
          end
        end
        SETUP: begin
          wait_cnt <= '0;
          rdata_q  <= '0;
          err_q    <= 1'b0;
        end
        ACCESS: begin
          // a completion on the timeout cycle takes priority over the abort
          if (bus.PREADY) begin
            rdata_q <= cur.write ? '0 : bus.PRDATA;
          end else if (wait_cnt == WAIT_LAST) begin
            err_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // address and data keep their last values while the bus is idle
  assign bus.PSEL      = (state == SETUP) || (state == ACCESS);
  assign bus.PENABLE   = (state == ACCESS);
  assign bus.PWRITE    = bus.PSEL & cur.write;
  assign bus.PADDR     = cur.addr[AW-1:0];
  assign bus.PWDATA    = cur.wdata[DW-1:0];
  assign bus.PWAIT     = WAIT_CFG;

  assign bus.req_ready = (state == IDLE && !PRESET) ? gnt : 2'b00;
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_id    = bus.rsp_valid & cur_id;
  assign bus.rsp_rdata = bus.rsp_valid ? rdata_q : '0;
  assign bus.rsp_err   = bus.rsp_valid & err_q;

endmodule
